// File: rtl/led_div_ctrl.sv
// Push-button front end for the LED counter: debounces up/down buttons into a saturating divider
// value with a one-cycle write strobe. Define LED_DIV_AUTOREPEAT_EN to step repeatedly while held.

module led_div_btn #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_CYC   = 50000000
) (
  input  logic clk100,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } btn_state_e;

  logic [1:0]       sync_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             busy_q;
  logic             s;

`ifdef LED_DIV_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] rep_q;
`endif

  assign s = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk100) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LED_DIV_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (s) begin
            state_q <= DB_PRESS;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        DB_PRESS: begin
          if (!s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
`ifdef LED_DIV_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state_q <= DB_REL;
            cnt_q   <= CNT_ONE;
          end
`ifdef LED_DIV_AUTOREPEAT_EN
          else if (rep_q == REP_LAST) begin
            rep_q   <= '0;
            press_q <= 1'b1;
          end else begin
            rep_q <= rep_q + REP_ONE;
          end
`endif
        end
        DB_REL: begin
          // A bounce back to 1 resumes the hold; the repeat count is kept, not restarted.
          if (s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign press_o = press_q;
  assign busy_o  = busy_q;

endmodule

module led_div_ctrl #(
  parameter int DIV_W        = 5,
  parameter int DIV_INIT     = 3,
  parameter int DIV_MIN      = 0,
  parameter int DIV_MAX      = 31,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_CYC   = 50000000
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_INI_V = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_MAX_V = DIV_W'(DIV_MAX);

  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("led_div_ctrl: DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_CYC < 2) begin : g_bad_repeat
    $error("led_div_ctrl: REPEAT_CYC must be >= 2");
  end
  if (DIV_MIN > DIV_INIT || DIV_INIT > DIV_MAX || DIV_MAX > (2**DIV_W) - 1) begin : g_bad_bounds
    $error("led_div_ctrl: need DIV_MIN <= DIV_INIT <= DIV_MAX <= 2**DIV_W-1");
  end

  logic             up_press, dn_press;
  logic             up_busy, dn_busy;
  logic             up_evt_q, dn_evt_q;
  logic             boot_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wren_q, wren_d;

  led_div_btn #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_btn_up (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_up_i),
    .press_o (up_press),
    .busy_o  (up_busy)
  );

  led_div_btn #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_btn_dn (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_dn_i),
    .press_o (dn_press),
    .busy_o  (dn_busy)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    div_d  = div_q;
    wren_d = boot_q;
    if (up_evt_q && !dn_evt_q && (div_q < DIV_MAX_V)) begin
      div_d  = div_q + DIV_ONE;
      wren_d = 1'b1;
    end else if (dn_evt_q && !up_evt_q && (div_q > DIV_MIN_V)) begin
      div_d  = div_q - DIV_ONE;
      wren_d = 1'b1;
    end
  end

  // boot_q survives reset as 1 so the first running edge writes DIV_INIT downstream.
  always_ff @(posedge clk100) begin
    if (!rst) begin
      up_evt_q <= 1'b0;
      dn_evt_q <= 1'b0;
      boot_q   <= 1'b1;
      div_q    <= DIV_INI_V;
      wren_q   <= 1'b0;
    end else begin
      up_evt_q <= up_press;
      dn_evt_q <= dn_press;
      boot_q   <= 1'b0;
      div_q    <= div_d;
      wren_q   <= wren_d;
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;
  assign busy_o = up_busy | dn_busy;

endmodule

// File: tb/tb_led_div_ctrl.sv
// Directed bench for led_div_ctrl with DEBOUNCE_CYC = 8, REPEAT_CYC = 20; define
// LED_DIV_AUTOREPEAT_EN on both RTL and bench to exercise the auto-repeat build.

module tb_led_div_ctrl;

  localparam int DB = 8;
  localparam int RP = 20;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [4:0] div;
  logic       wren;
  logic       busy;

  int n_vec    = 0;
  int n_err    = 0;
  int wren_cnt = 0;
  int base     = 0;

  led_div_ctrl #(
    .DIV_W        (5),
    .DIV_INIT     (3),
    .DIV_MIN      (0),
    .DIV_MAX      (31),
    .DEBOUNCE_CYC (DB),
    .REPEAT_CYC   (RP)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .btn_up_i (btn_up),
    .btn_dn_i (btn_dn),
    .div_o    (div),
    .wren_o   (wren),
    .busy_o   (busy)
  );

  always #5 clk100 = ~clk100;

  always @(negedge clk100) begin
    if (wren === 1'b1) wren_cnt <= wren_cnt + 1;
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic reset_dut();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst    = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic press(input logic up, input logic dn, input int n_high);
    btn_up = up;
    btn_dn = dn;
    repeat (n_high) tick();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst    = 1'b0;
    repeat (2) tick();
    if (div !== 5'd3) begin $display("FAIL rst_div: got %0d expected 3", div); n_err++; end
    n_vec++;
    if (wren !== 1'b0) begin $display("FAIL rst_wren: got %b expected 0", wren); n_err++; end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b expected 0", busy); n_err++; end
    n_vec++;
    base = wren_cnt;
    rst  = 1'b1;
    tick();
    if (wren !== 1'b1) begin $display("FAIL boot_wren: got %b expected 1", wren); n_err++; end
    n_vec++;
    if (div !== 5'd3) begin $display("FAIL boot_div: got %0d expected 3", div); n_err++; end
    n_vec++;
    tick();
    if (wren !== 1'b0) begin $display("FAIL boot_wren_end: got %b expected 0", wren); n_err++; end
    n_vec++;
    repeat (5) tick();
    if (wren_cnt - base !== 1) begin
      $display("FAIL boot_count: got %0d pulses expected 1", wren_cnt - base); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_glitch();
    base   = wren_cnt;
    btn_dn = 1'b1;
    repeat (5) tick();
    if (busy !== 1'b1) begin $display("FAIL glitch_busy: got %b expected 1", busy); n_err++; end
    n_vec++;
    btn_dn = 1'b0;
    repeat (12) tick();
    if (div !== 5'd3) begin $display("FAIL glitch_div: got %0d expected 3", div); n_err++; end
    n_vec++;
    if (wren_cnt - base !== 0) begin
      $display("FAIL glitch_wren: got %0d pulses expected 0", wren_cnt - base); n_err++;
    end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL glitch_idle: got %b expected 0", busy); n_err++; end
    n_vec++;
  endtask

  task automatic test_single_up();
    base   = wren_cnt;
    btn_up = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 2 && busy !== 1'b0) begin $display("FAIL up_busy_pre: got %b expected 0", busy); n_err++; end
      if (i == 2) n_vec++;
      if (i == 3 && busy !== 1'b1) begin $display("FAIL up_busy_on: got %b expected 1", busy); n_err++; end
      if (i == 3) n_vec++;
      if (i == 11 && (wren !== 1'b0 || div !== 5'd3)) begin
        $display("FAIL up_early: got wren=%b div=%0d expected wren=0 div=3", wren, div); n_err++;
      end
      if (i == 11) n_vec++;
      if (i == 12 && (wren !== 1'b1 || div !== 5'd4)) begin
        $display("FAIL up_step: got wren=%b div=%0d expected wren=1 div=4", wren, div); n_err++;
      end
      if (i == 12) n_vec++;
      if (i == 13 && wren !== 1'b0) begin $display("FAIL up_pulse_width: got %b expected 0", wren); n_err++; end
      if (i == 13) n_vec++;
    end
    btn_up = 1'b0;
    for (int r = 1; r <= 12; r++) begin
      tick();
      if (r == 9 && busy !== 1'b1) begin $display("FAIL up_rel_busy: got %b expected 1", busy); n_err++; end
      if (r == 9) n_vec++;
      if (r == 10 && busy !== 1'b0) begin $display("FAIL up_rel_idle: got %b expected 0", busy); n_err++; end
      if (r == 10) n_vec++;
    end
    if (div !== 5'd4 || wren_cnt - base !== 1) begin
      $display("FAIL up_total: got div=%0d pulses=%0d expected div=4 pulses=1", div, wren_cnt - base); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_saturation();
    reset_dut();
    base = wren_cnt;
    repeat (28) press(1'b1, 1'b0, 10);
    if (div !== 5'd31 || wren_cnt - base !== 28) begin
      $display("FAIL sat_up_climb: got div=%0d pulses=%0d expected div=31 pulses=28", div, wren_cnt - base); n_err++;
    end
    n_vec++;
    base = wren_cnt;
    press(1'b1, 1'b0, 10);
    if (div !== 5'd31 || wren_cnt - base !== 0) begin
      $display("FAIL sat_up_hold: got div=%0d pulses=%0d expected div=31 pulses=0", div, wren_cnt - base); n_err++;
    end
    n_vec++;
    base = wren_cnt;
    repeat (31) press(1'b0, 1'b1, 10);
    if (div !== 5'd0 || wren_cnt - base !== 31) begin
      $display("FAIL sat_dn_fall: got div=%0d pulses=%0d expected div=0 pulses=31", div, wren_cnt - base); n_err++;
    end
    n_vec++;
    base = wren_cnt;
    press(1'b0, 1'b1, 10);
    if (div !== 5'd0 || wren_cnt - base !== 0) begin
      $display("FAIL sat_dn_hold: got div=%0d pulses=%0d expected div=0 pulses=0", div, wren_cnt - base); n_err++;
    end
    n_vec++;
  endtask

  task automatic test_simultaneous();
    repeat (3) press(1'b1, 1'b0, 10);
    base = wren_cnt;
    press(1'b1, 1'b1, 15);
    if (div !== 5'd3 || wren_cnt - base !== 0) begin
      $display("FAIL both_btn: got div=%0d pulses=%0d expected div=3 pulses=0", div, wren_cnt - base); n_err++;
    end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL both_idle: got %b expected 0", busy); n_err++; end
    n_vec++;
  endtask

  task automatic test_reset_mid_debounce();
    reset_dut();
    btn_up = 1'b1;
    repeat (9) tick();
    base = wren_cnt;
    rst  = 1'b0;
    tick();
    if (busy !== 1'b0) begin $display("FAIL mid_rst_busy: got %b expected 0", busy); n_err++; end
    n_vec++;
    btn_up = 1'b0;
    tick();
    rst = 1'b1;
    repeat (14) tick();
    if (div !== 5'd3 || wren_cnt - base !== 1) begin
      $display("FAIL mid_rst_event: got div=%0d pulses=%0d expected div=3 pulses=1", div, wren_cnt - base); n_err++;
    end
    n_vec++;
  endtask

`ifdef LED_DIV_AUTOREPEAT_EN
  task automatic test_autorepeat();
    reset_dut();
    base   = wren_cnt;
    btn_up = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      tick();
      if ((i == 12 || i == 32 || i == 52) && wren !== 1'b1) begin
        $display("FAIL rep_pulse_%0d: got %b expected 1", i, wren); n_err++;
      end
      if (i == 12 || i == 32 || i == 52) n_vec++;
      if ((i == 31 || i == 51) && wren !== 1'b0) begin
        $display("FAIL rep_gap_%0d: got %b expected 0", i, wren); n_err++;
      end
      if (i == 31 || i == 51) n_vec++;
    end
    btn_up = 1'b0;
    repeat (12) tick();
    if (div !== 5'd6 || wren_cnt - base !== 3) begin
      $display("FAIL rep_total: got div=%0d pulses=%0d expected div=6 pulses=3", div, wren_cnt - base); n_err++;
    end
    n_vec++;
    reset_dut();
    btn_up = 1'b1;
    repeat (49) tick();
    if (div !== 5'd5) begin $display("FAIL rep_pre_rst: got %0d expected 5", div); n_err++; end
    n_vec++;
    base = wren_cnt;
    rst  = 1'b0;
    tick();
    btn_up = 1'b0;
    tick();
    rst = 1'b1;
    repeat (30) tick();
    if (div !== 5'd3 || wren_cnt - base !== 1) begin
      $display("FAIL rep_mid_rst: got div=%0d pulses=%0d expected div=3 pulses=1", div, wren_cnt - base); n_err++;
    end
    n_vec++;
  endtask
`else
  task automatic test_long_hold();
    reset_dut();
    base = wren_cnt;
    press(1'b1, 1'b0, 65);
    if (div !== 5'd4 || wren_cnt - base !== 1) begin
      $display("FAIL long_hold: got div=%0d pulses=%0d expected div=4 pulses=1", div, wren_cnt - base); n_err++;
    end
    n_vec++;
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_single_up();
    test_saturation();
    test_simultaneous();
    test_reset_mid_debounce();
`ifdef LED_DIV_AUTOREPEAT_EN
    test_autorepeat();
`else
    test_long_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
